mem_wb_writeback: RTL

Registered MEM/WB pipeline stage and write-back selector for the MIPS core: it latches the MEM-stage results, extracts and extends sub-word load data, selects the write-back value, and drives the register-file write port. It replaces the plain two-input write-back multiplexer with a parametrised, stallable and flushable stage that has three write-back sources and counts retired instructions.

---
 rtl/mem_wb_writeback.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline stage with write-back source selection and retired-instruction counter.
// Optional macro WB_LOAD_EXT_EN enables sub-word load extraction and extension.
module mem_wb_writeback #(
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned NB_REG_ADDR = 5,
    parameter int unsigned NB_SELECTOR = 2,
    parameter int unsigned NB_COUNT    = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic [NB_DATA-1:0]     i_data_alu,
    input  logic [NB_DATA-1:0]     i_data_mem,
    input  logic [NB_DATA-1:0]     i_pc_link,
    input  logic [NB_SELECTOR-1:0] i_selector,
    input  logic [1:0]             i_load_size,
    input  logic                   i_load_unsigned,
    input  logic [1:0]             i_byte_off,
    input  logic                   i_reg_write,
    input  logic [NB_REG_ADDR-1:0] i_rd,
    output logic [NB_DATA-1:0]     o_wb_data,
    output logic [NB_REG_ADDR-1:0] o_wb_rd,
    output logic                   o_wb_we,
    output logic [NB_COUNT-1:0]    o_retired
);

    localparam int unsigned NB_BYTE = 8;
    localparam int unsigned NB_HALF = 16;

    logic                   valid;
    logic [NB_DATA-1:0]     data_alu;
    logic [NB_DATA-1:0]     data_mem;
    logic [NB_DATA-1:0]     pc_link;
    logic [NB_SELECTOR-1:0] selector;
    logic                   reg_write;
    logic [NB_REG_ADDR-1:0] rd;
    logic [NB_COUNT-1:0]    retired;
    logic [NB_DATA-1:0]     mem_ext;

    // Stage register: flush clears valid only, stall holds, otherwise load.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid     <= 1'b0;
            data_alu  <= '0;
            data_mem  <= '0;
            pc_link   <= '0;
            selector  <= '0;
            reg_write <= 1'b0;
            rd        <= '0;
        end else if (i_flush) begin
            valid <= 1'b0;
        end else if (!i_stall) begin
            valid     <= i_valid;
            data_alu  <= i_data_alu;
            data_mem  <= i_data_mem;
            pc_link   <= i_pc_link;
            selector  <= i_selector;
            reg_write <= i_reg_write;
            rd        <= i_rd;
        end
    end

    // An entry retires when it leaves the stage, even if a flush hits on the same edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            retired <= '0;
        end else if (valid && !i_stall) begin
            retired <= retired + NB_COUNT'(1);
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [1:0]         load_size;
    logic               load_unsigned;
    logic [1:0]         byte_off;
    logic [NB_DATA-1:0] byte_shift;
    logic [NB_DATA-1:0] half_shift;
    logic [NB_BYTE-1:0] byte_sel;
    logic [NB_HALF-1:0] half_sel;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            load_size     <= 2'b00;
            load_unsigned <= 1'b0;
            byte_off      <= 2'b00;
        end else if (!i_flush && !i_stall) begin
            load_size     <= i_load_size;
            load_unsigned <= i_load_unsigned;
            byte_off      <= i_byte_off;
        end
    end

    // Little-endian lane select; half loads ignore the low offset bit.
    assign byte_shift = data_mem >> {byte_off, 3'b000};
    assign half_shift = data_mem >> {byte_off[1], 4'b0000};
    assign byte_sel   = byte_shift[NB_BYTE-1:0];
    assign half_sel   = half_shift[NB_HALF-1:0];

    always_comb begin
        mem_ext = data_mem;
        case (load_size)
            2'b00: begin
                if (load_unsigned) mem_ext = {{(NB_DATA-NB_BYTE){1'b0}}, byte_sel};
                else               mem_ext = {{(NB_DATA-NB_BYTE){byte_sel[NB_BYTE-1]}}, byte_sel};
            end
            2'b01: begin
                if (load_unsigned) mem_ext = {{(NB_DATA-NB_HALF){1'b0}}, half_sel};
                else               mem_ext = {{(NB_DATA-NB_HALF){half_sel[NB_HALF-1]}}, half_sel};
            end
            default: mem_ext = data_mem;
        endcase
    end
`else
    logic unused_load_ctrl;

    assign unused_load_ctrl = ^{i_load_size, i_load_unsigned, i_byte_off};
    assign mem_ext          = data_mem;
`endif

    // Write-back source select; the reserved code drives zero.
    always_comb begin
        o_wb_data = '0;
        case (selector)
            NB_SELECTOR'(0): o_wb_data = data_alu;
            NB_SELECTOR'(1): o_wb_data = mem_ext;
            NB_SELECTOR'(2): o_wb_data = pc_link;
            default:         o_wb_data = '0;
        endcase
    end

    assign o_wb_we   = valid && reg_write && (rd != '0);
    assign o_wb_rd   = rd;
    assign o_retired = retired;

endmodule
